arb_req_queue: RTL

ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

---
 rtl/arb_req_queue.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/arb_req_queue.sv
// arb_req_queue
// Four independent per-requester FIFOs that share one output register.
// REQ advertises which FIFOs hold data to an external round-robin arbiter,
// whose one-hot GNT selects the FIFO that refills the output register.
// A malformed (multi-hot) grant is ignored and recorded in the sticky gnt_err.
// Optional feature: define ARB_REQ_QUEUE_STATS_EN to add stat_cnt, four
// wrapping 8-bit pop counters (requester i in bits [8i +: 8]).
module arb_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic [3:0]          REQ,
    input  logic [3:0]          GNT,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_id,
    input  logic                out_ready,
`ifdef ARB_REQ_QUEUE_STATS_EN
    output logic                gnt_err,
    output logic [31:0]         stat_cnt
`else
    output logic                gnt_err
`endif
);

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // needs one extra bit so that full (DEPTH) and empty (0) stay distinct.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // A grant is usable only when exactly one bit is set.
    function automatic logic gnt_is_onehot(input logic [3:0] g);
        return (g != 4'd0) && ((g & (g - 4'd1)) == 4'd0);
    endfunction

    // Binary index of the set grant bit (meaningful only for one-hot grants).
    function automatic logic [1:0] gnt_index(input logic [3:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // FIFO stage state
    logic [DATA_W-1:0] mem_p0    [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_p0 [4];
    logic [PTR_W-1:0]  rd_ptr_p0 [4];
    logic [CNT_W-1:0]  cnt_p0    [4];

    // Output stage state
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [1:0]        id_p1;
    logic              gnt_err_q;

    // Per-cycle steering decisions
    logic              gnt_ok;
    logic              gnt_bad;
    logic              out_free;
    logic [1:0]        pop_sel;
    logic [3:0]        pop_vec;
    logic              pop_any;
    logic [3:0]        push_vec;
    logic [DATA_W-1:0] head_word;

    // Flow-control flags depend only on the registered counts.
    always_comb begin
        in_ready = 4'd0;
        REQ      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = (cnt_p0[i] != CNT_FULL);
            REQ[i]      = (cnt_p0[i] != '0);
        end
    end

    // Push/pop selection; a grant to an empty FIFO simply pops nothing.
    always_comb begin
        gnt_ok    = gnt_is_onehot(GNT);
        gnt_bad   = (GNT != 4'd0) && !gnt_ok;
        out_free  = !vld_p1 || out_ready;
        pop_sel   = gnt_index(GNT);
        pop_vec   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            pop_vec[i] = out_free && gnt_ok && GNT[i] && REQ[i];
        end
        pop_any   = |pop_vec;
        push_vec  = in_valid & in_ready;
        head_word = mem_p0[pop_sel][rd_ptr_p0[pop_sel]];
    end

    // FIFO storage: written on push, never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_vec[i]) begin
                mem_p0[i][wr_ptr_p0[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers and counts; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_p0[i] <= '0;
                rd_ptr_p0[i] <= '0;
                cnt_p0[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_vec[i]) wr_ptr_p0[i] <= wr_ptr_p0[i] + PTR_W'(1);
                if (pop_vec[i])  rd_ptr_p0[i] <= rd_ptr_p0[i] + PTR_W'(1);
                case ({push_vec[i], pop_vec[i]})
                    2'b10:   cnt_p0[i] <= cnt_p0[i] + CNT_W'(1);
                    2'b01:   cnt_p0[i] <= cnt_p0[i] - CNT_W'(1);
                    default: cnt_p0[i] <= cnt_p0[i];
                endcase
            end
        end
    end

    // Output register: load on pop, drop on consume, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= 2'd0;
        end else if (pop_any) begin
            vld_p1  <= 1'b1;
            data_p1 <= head_word;
            id_p1   <= pop_sel;
        end else if (vld_p1 && out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Sticky malformed-grant flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_err_q <= 1'b0;
        end else if (gnt_bad) begin
            gnt_err_q <= 1'b1;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_id    = id_p1;
    assign gnt_err   = gnt_err_q;

`ifdef ARB_REQ_QUEUE_STATS_EN
    logic [7:0] stat_p1 [4];

    // Per-requester pop counters, wrapping 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) stat_p1[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop_vec[i]) stat_p1[i] <= stat_p1[i] + 8'd1;
            end
        end
    end

    assign stat_cnt = {stat_p1[3], stat_p1[2], stat_p1[1], stat_p1[0]};
`endif

endmodule
